// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle control unit:
//   - state_t   : FSM state encoding (visible on the unit's 'state' port)
//   - cls_t     : instruction class derived from the 7-bit major opcode
//   - OPC_*     : major opcode values recognised by the decoder
//   - ALU_*     : 4-bit ALU operation codes driven to the datapath
//   - decode_class() : major opcode -> instruction class
// ---------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_I       = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_HALT    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } cls_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_HALT   = 7'b1111111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    function automatic cls_t decode_class(input logic [6:0] opc);
        cls_t c;
        case (opc)
            OPC_R:      c = CLS_R;
            OPC_I:      c = CLS_I;
            OPC_LOAD:   c = CLS_LOAD;
            OPC_STORE:  c = CLS_STORE;
            OPC_BRANCH: c = CLS_BRANCH;
            OPC_HALT:   c = CLS_HALT;
            default:    c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_decode.sv
// ---------------------------------------------------------------------------
// alu_decode
// Combinational decode of the latched instruction register.
// Ports:
//   ir      in  32  latched instruction word
//   alu_op  out 4   ALU operation code for the datapath
//   alu_src out 1   1 = immediate operand, 0 = RS2
//   cls     out 3   instruction class (cls_t)
// ---------------------------------------------------------------------------
module alu_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output logic [3:0]  alu_op,
    output logic        alu_src,
    output cls_t        cls
);

    logic [2:0] funct3;
    logic       funct7b5;
    logic       unused_ir_bits;

    assign funct3         = ir[14:12];
    assign funct7b5       = ir[30];
    assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};

    // funct3 -> ALU code. sub_sel only distinguishes ADD/SUB; the shift-right
    // slot always maps to SRL since there is no arithmetic-shift code.
    function automatic logic [3:0] funct_to_alu(input logic [2:0] f3,
                                                input logic       sub_sel);
        logic [3:0] op;
        case (f3)
            3'b000:  op = sub_sel ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLT;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        cls     = decode_class(ir[6:0]);
        alu_op  = ALU_ADD;
        alu_src = 1'b0;
        case (cls)
            CLS_R: begin
                alu_op = funct_to_alu(funct3, funct7b5);
            end
            CLS_I: begin
                // bit 30 is immediate data for I-type, never a SUB select
                alu_op  = funct_to_alu(funct3, 1'b0);
                alu_src = 1'b1;
            end
            CLS_LOAD, CLS_STORE: begin
                alu_op  = ALU_ADD;
                alu_src = 1'b1;
            end
            CLS_BRANCH: begin
                alu_op = ALU_SUB;
            end
            default: begin
                alu_op  = ALU_ADD;
                alu_src = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
// Multicycle sequencer for the datapath: FETCH, DECODE, EXEC, MEM, WB, HALT.
// All outputs are registered and reflect the state entered at the last edge.
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous active-low reset
//   run       in   1      advance enable (0 freezes everything)
//   instr     in   32     ROM word at current PC
//   zero      in   1      ALU zero flag
//   opcode    out  4      ALU operation code (valid EXEC..WB)
//   ALUsrc    out  1      1 = immediate operand
//   RegWrite  out  1      register-file write enable
//   MemRW     out  1      1 = RAM write
//   MemtoReg  out  1      1 = RAM data to register file
//   PCsrc     out  1      1 = PC+imm, 0 = PC+4
//   pc_we     out  1      PC load enable, one cycle per retired instruction
//   state     out  3      current state code
//   illegal   out  1      pulse in DECODE for unknown opcode
//   halted    out  1      1 while in HALT
//   retired   out  CNT_W  retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter bit          ILLEGAL_HALT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [31:0]      instr,
    input  logic             zero,
    output logic [3:0]       opcode,
    output logic             ALUsrc,
    output logic             RegWrite,
    output logic             MemRW,
    output logic             MemtoReg,
    output logic             PCsrc,
    output logic             pc_we,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_t      cur;
    logic [31:0] ir;
    logic [3:0]  dec_op;
    logic        dec_src;
    cls_t        dec_cls;
    cls_t        fetch_cls;
    logic        taken;

    alu_decode u_alu_decode (
        .ir      (ir),
        .alu_op  (dec_op),
        .alu_src (dec_src),
        .cls     (dec_cls)
    );

    assign state     = cur;
    assign fetch_cls = decode_class(instr[6:0]);
    assign taken     = ((ir[14:12] == 3'b000) &&  zero) ||
                       ((ir[14:12] == 3'b001) && !zero);

    // The word is captured into IR on the edge entering DECODE, so DECODE and
    // everything after it decodes from IR. The illegal flag is registered on
    // that same edge from the word being captured, so it is high in DECODE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur      <= FETCH;
            ir       <= '0;
            retired  <= '0;
            opcode   <= '0;
            ALUsrc   <= 1'b0;
            RegWrite <= 1'b0;
            MemRW    <= 1'b0;
            MemtoReg <= 1'b0;
            PCsrc    <= 1'b0;
            pc_we    <= 1'b0;
            illegal  <= 1'b0;
            halted   <= 1'b0;
        end else if (run) begin
            // strobes are single-shot per state visit
            RegWrite <= 1'b0;
            MemRW    <= 1'b0;
            MemtoReg <= 1'b0;
            PCsrc    <= 1'b0;
            pc_we    <= 1'b0;
            illegal  <= 1'b0;

            case (cur)
                FETCH: begin
                    cur     <= DECODE;
                    ir      <= instr;
                    opcode  <= '0;
                    ALUsrc  <= 1'b0;
                    illegal <= (fetch_cls == CLS_ILLEGAL);
                end

                DECODE: begin
                    case (dec_cls)
                        CLS_HALT: begin
                            cur    <= HALT;
                            halted <= 1'b1;
                        end
                        CLS_ILLEGAL: begin
                            if (ILLEGAL_HALT) begin
                                cur    <= HALT;
                                halted <= 1'b1;
                            end else begin
                                cur     <= FETCH;
                                pc_we   <= 1'b1;
                                retired <= retired + CNT_W'(1);
                            end
                        end
                        default: begin
                            cur    <= EXEC;
                            opcode <= dec_op;
                            ALUsrc <= dec_src;
                            if (dec_cls == CLS_BRANCH) begin
                                PCsrc   <= taken;
                                pc_we   <= 1'b1;
                                retired <= retired + CNT_W'(1);
                            end
                        end
                    endcase
                end

                EXEC: begin
                    case (dec_cls)
                        CLS_R, CLS_I: begin
                            cur      <= WB;
                            RegWrite <= 1'b1;
                            pc_we    <= 1'b1;
                            retired  <= retired + CNT_W'(1);
                        end
                        CLS_LOAD: begin
                            cur <= MEM;
                        end
                        CLS_STORE: begin
                            cur     <= MEM;
                            MemRW   <= 1'b1;
                            pc_we   <= 1'b1;
                            retired <= retired + CNT_W'(1);
                        end
                        default: begin
                            // branch already retired on entry to EXEC
                            cur    <= FETCH;
                            opcode <= '0;
                            ALUsrc <= 1'b0;
                        end
                    endcase
                end

                MEM: begin
                    if (dec_cls == CLS_LOAD) begin
                        cur      <= WB;
                        RegWrite <= 1'b1;
                        MemtoReg <= 1'b1;
                        pc_we    <= 1'b1;
                        retired  <= retired + CNT_W'(1);
                    end else begin
                        cur    <= FETCH;
                        opcode <= '0;
                        ALUsrc <= 1'b0;
                    end
                end

                WB: begin
                    cur    <= FETCH;
                    opcode <= '0;
                    ALUsrc <= 1'b0;
                end

                HALT: begin
                    cur    <= HALT;
                    halted <= 1'b1;
                end

                default: begin
                    cur    <= FETCH;
                    opcode <= '0;
                    ALUsrc <= 1'b0;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
// Table-driven check of the multicycle control unit plus hand-written
// sequences for HALT, reset mid-instruction and counter wrap.
// dut_a: CNT_W=4, illegal retires as NOP. dut_b: CNT_W=16, illegal halts.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

    localparam logic [7:0] F_SRC = 8'h80;
    localparam logic [7:0] F_RW  = 8'h40;
    localparam logic [7:0] F_MW  = 8'h20;
    localparam logic [7:0] F_M2R = 8'h10;
    localparam logic [7:0] F_PCS = 8'h08;
    localparam logic [7:0] F_PCW = 8'h04;
    localparam logic [7:0] F_ILL = 8'h02;
    localparam logic [7:0] F_HLT = 8'h01;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h40208233;
    localparam logic [31:0] I_AND  = 32'h0020F2B3;
    localparam logic [31:0] I_XOR  = 32'h0020C2B3;
    localparam logic [31:0] I_SRL  = 32'h0020D2B3;
    localparam logic [31:0] I_SLT  = 32'h0020A2B3;
    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_ADDB = 32'h40000093;
    localparam logic [31:0] I_ORI  = 32'h0010E093;
    localparam logic [31:0] I_SLLI = 32'h00309093;
    localparam logic [31:0] I_SRAI = 32'h4030D093;
    localparam logic [31:0] I_LW   = 32'h0000A283;
    localparam logic [31:0] I_SW   = 32'h0050A223;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_ILL  = 32'h0000007B;
    localparam logic [31:0] I_HLT  = 32'h0000007F;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] instr;
    logic        zero;

    logic [3:0] a_opcode, b_opcode;
    logic       a_ALUsrc, a_RegWrite, a_MemRW, a_MemtoReg, a_PCsrc, a_pc_we;
    logic       b_ALUsrc, b_RegWrite, b_MemRW, b_MemtoReg, b_PCsrc, b_pc_we;
    logic [2:0] a_state, b_state;
    logic       a_illegal, a_halted, b_illegal, b_halted;
    logic [3:0] a_retired;
    logic [15:0] b_retired;
    logic [7:0] a_flags;

    assign a_flags = {a_ALUsrc, a_RegWrite, a_MemRW, a_MemtoReg,
                      a_PCsrc, a_pc_we, a_illegal, a_halted};

    always #5 clk = ~clk;

    multicycle_control_unit #(.CNT_W(4), .ILLEGAL_HALT(1'b0)) dut_a (
        .clk(clk), .reset(reset), .run(run), .instr(instr), .zero(zero),
        .opcode(a_opcode), .ALUsrc(a_ALUsrc), .RegWrite(a_RegWrite),
        .MemRW(a_MemRW), .MemtoReg(a_MemtoReg), .PCsrc(a_PCsrc),
        .pc_we(a_pc_we), .state(a_state), .illegal(a_illegal),
        .halted(a_halted), .retired(a_retired)
    );

    multicycle_control_unit #(.CNT_W(16), .ILLEGAL_HALT(1'b1)) dut_b (
        .clk(clk), .reset(reset), .run(run), .instr(instr), .zero(zero),
        .opcode(b_opcode), .ALUsrc(b_ALUsrc), .RegWrite(b_RegWrite),
        .MemRW(b_MemRW), .MemtoReg(b_MemtoReg), .PCsrc(b_PCsrc),
        .pc_we(b_pc_we), .state(b_state), .illegal(b_illegal),
        .halted(b_halted), .retired(b_retired)
    );

    typedef struct {
        logic        run;
        logic [31:0] instr;
        logic        zero;
        logic [2:0]  st;
        logic [3:0]  op;
        logic [7:0]  fl;
    } vec_t;

    vec_t       vecs[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] exp_ret;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [31:0] i, input logic z);
        run   = r;
        instr = i;
        zero  = z;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [31:0] i, input logic z,
                       input logic [2:0] s, input logic [3:0] op, input logic [7:0] f);
        vec_t v;
        v.run = r; v.instr = i; v.zero = z; v.st = s; v.op = op; v.fl = f;
        vecs.push_back(v);
    endtask

    // R/I-type: DECODE, EXEC, WB (retire), back to FETCH
    task automatic add_ri(input logic [31:0] i, input logic [3:0] op, input logic src);
        logic [7:0] s;
        s = src ? F_SRC : 8'h00;
        add(1'b1, i, 1'b0, 3'd1, 4'd0, 8'h00);
        add(1'b1, i, 1'b0, 3'd2, op, s);
        add(1'b1, i, 1'b0, 3'd4, op, s | F_RW | F_PCW);
        add(1'b1, i, 1'b0, 3'd0, 4'd0, 8'h00);
    endtask

    // branch: DECODE, EXEC (retire), FETCH
    task automatic add_br(input logic [31:0] i, input logic z, input logic tk);
        add(1'b1, i, z, 3'd1, 4'd0, 8'h00);
        add(1'b1, i, z, 3'd2, 4'd1, F_PCW | (tk ? F_PCS : 8'h00));
        add(1'b1, i, z, 3'd0, 4'd0, 8'h00);
    endtask

    initial begin
        // ---------------- vector table ----------------
        add_ri(I_ADD,  4'd0, 1'b0);
        add_ri(I_SUB,  4'd1, 1'b0);
        add_ri(I_AND,  4'd2, 1'b0);
        add_ri(I_XOR,  4'd4, 1'b0);
        add_ri(I_SRL,  4'd6, 1'b0);
        add_ri(I_SLT,  4'd7, 1'b0);
        add_ri(I_ADDI, 4'd0, 1'b1);
        add_ri(I_ADDB, 4'd0, 1'b1);
        add_ri(I_ORI,  4'd3, 1'b1);
        add_ri(I_SLLI, 4'd5, 1'b1);
        add_ri(I_SRAI, 4'd6, 1'b1);
        // LW: 5 cycles, MemtoReg with RegWrite in WB
        add(1'b1, I_LW, 1'b0, 3'd1, 4'd0, 8'h00);
        add(1'b1, I_LW, 1'b0, 3'd2, 4'd0, F_SRC);
        add(1'b1, I_LW, 1'b0, 3'd3, 4'd0, F_SRC);
        add(1'b1, I_LW, 1'b0, 3'd4, 4'd0, F_SRC | F_RW | F_M2R | F_PCW);
        add(1'b1, I_LW, 1'b0, 3'd0, 4'd0, 8'h00);
        // SW: 4 cycles, MemRW with pc_we in MEM, no RegWrite
        add(1'b1, I_SW, 1'b0, 3'd1, 4'd0, 8'h00);
        add(1'b1, I_SW, 1'b0, 3'd2, 4'd0, F_SRC);
        add(1'b1, I_SW, 1'b0, 3'd3, 4'd0, F_SRC | F_MW | F_PCW);
        add(1'b1, I_SW, 1'b0, 3'd0, 4'd0, 8'h00);
        // branches
        add_br(I_BEQ, 1'b1, 1'b1);
        add_br(I_BEQ, 1'b0, 1'b0);
        add_br(I_BNE, 1'b1, 1'b0);
        add_br(I_BNE, 1'b0, 1'b1);
        // ADD stalled 5 cycles in EXEC and 2 in WB
        add(1'b1, I_ADD, 1'b0, 3'd1, 4'd0, 8'h00);
        add(1'b1, I_ADD, 1'b0, 3'd2, 4'd0, 8'h00);
        for (int k = 0; k < 5; k++) add(1'b0, I_ADD, 1'b0, 3'd2, 4'd0, 8'h00);
        add(1'b1, I_ADD, 1'b0, 3'd4, 4'd0, F_RW | F_PCW);
        add(1'b0, I_ADD, 1'b0, 3'd4, 4'd0, F_RW | F_PCW);
        add(1'b0, I_ADD, 1'b0, 3'd4, 4'd0, F_RW | F_PCW);
        add(1'b1, I_ADD, 1'b0, 3'd0, 4'd0, 8'h00);
        // illegal word retires as a NOP on dut_a, then a frozen FETCH
        add(1'b1, I_ILL, 1'b0, 3'd1, 4'd0, F_ILL);
        add(1'b1, I_ILL, 1'b0, 3'd0, 4'd0, F_PCW);
        add(1'b0, I_ADD, 1'b0, 3'd0, 4'd0, F_PCW);

        // ---------------- reset ----------------
        reset = 1'b0;
        step(1'b1, I_ADD, 1'b0);
        step(1'b1, I_ADD, 1'b0);
        check("rst_state",   0, a_state,   3'd0);
        check("rst_opcode",  0, a_opcode,  4'd0);
        check("rst_flags",   0, a_flags,   8'h00);
        check("rst_retired", 0, a_retired, 4'd0);
        reset   = 1'b1;
        exp_ret = 4'd0;

        // ---------------- table run ----------------
        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].run, vecs[k].instr, vecs[k].zero);
            if (vecs[k].run && vecs[k].fl[2]) exp_ret = exp_ret + 4'd1;
            check("state",   k, a_state,   vecs[k].st);
            check("opcode",  k, a_opcode,  vecs[k].op);
            check("flags",   k, a_flags,   vecs[k].fl);
            check("retired", k, a_retired, exp_ret);
        end

        // dut_b took the illegal word into HALT
        check("b_ill_state",  0, b_state,  3'd5);
        check("b_ill_halted", 0, b_halted, 1'b1);
        check("b_ill_pcwe",   0, b_pc_we,  1'b0);

        // ---------------- HALT opcode on dut_a ----------------
        step(1'b1, I_HLT, 1'b0);
        check("hlt_decode", 0, a_state, 3'd1);
        check("hlt_flags0", 0, a_flags, 8'h00);
        step(1'b1, I_HLT, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("hlt_state",   k, a_state,   3'd5);
            check("hlt_flags",   k, a_flags,   F_HLT);
            check("hlt_retired", k, a_retired, exp_ret);
            check("b_hlt_state", k, b_state,   3'd5);
            step(k[0], I_ADD, 1'b0);
        end

        // ---------------- reset held mid-LOAD ----------------
        reset = 1'b0;
        step(1'b1, I_ADD, 1'b0);
        reset = 1'b1;
        check("rel_state",    0, a_state,  3'd0);
        check("rel_b_halted", 0, b_halted, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, I_ADD, 1'b0);
        check("pre_retired", 0, a_retired, 4'd1);
        for (int k = 0; k < 3; k++) step(1'b1, I_LW, 1'b0);
        check("mid_load_state", 0, a_state, 3'd3);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, I_LW, 1'b0);
            check("rstm_state",   k, a_state,   3'd0);
            check("rstm_retired", k, a_retired, 4'd0);
            check("rstm_flags",   k, a_flags,   8'h00);
            check("rstm_opcode",  k, a_opcode,  4'd0);
        end
        reset = 1'b1;

        // ---------------- counter wrap with CNT_W=4 ----------------
        for (int k = 1; k <= 16; k++) begin
            logic [3:0] kk;
            kk = 4'(k);
            step(1'b1, I_ADD, 1'b0);
            step(1'b1, I_ADD, 1'b0);
            step(1'b1, I_ADD, 1'b0);
            check("wrap_pcwe",    k, a_pc_we,   1'b1);
            check("wrap_retired", k, a_retired, kk);
            step(1'b1, I_ADD, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
